// File: rtl/regwrite_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
package regwrite_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    // Writeback source identifiers; also the encoding of the last-grant flag.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

endpackage

// File: rtl/regwrite_arbiter_if.sv
// Writeback bus: two producer request channels plus the register-file
// write port and the per-register busy vector returned to decode.
interface regwrite_arbiter_if #(
    parameter int DATA_W = regwrite_pkg::DATA_W,
    parameter int ADDR_W = regwrite_pkg::ADDR_W
);
    import regwrite_pkg::*;

    logic                aluValid;
    logic                aluReady;
    logic [ADDR_W-1:0]   aluReg;
    logic [DATA_W-1:0]   aluData;
    logic                memValid;
    logic                memReady;
    logic [ADDR_W-1:0]   memReg;
    logic [DATA_W-1:0]   memData;
    logic                regWrite;
    logic [ADDR_W-1:0]   writeReg;
    logic [DATA_W-1:0]   writeData;
    logic [NUM_REGS-1:0] busy;

    // Producer / register-file side.
    modport master (
        output aluValid, aluReg, aluData, memValid, memReg, memData,
        input  aluReady, memReady, regWrite, writeReg, writeData, busy
    );

    // Arbiter side.
    modport slave (
        input  aluValid, aluReg, aluData, memValid, memReg, memData,
        output aluReady, memReady, regWrite, writeReg, writeData, busy
    );

endinterface

// File: rtl/regwrite_arbiter_wb_fifo.sv
// Small circular FIFO of {reg, data} writeback entries. Besides the head it
// exposes every slot's valid bit and register index so the parent can build
// the busy vector without waiting for entries to reach the head.
module wb_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [ADDR_W-1:0]            push_reg_i,
    input  logic [DATA_W-1:0]            push_data_i,
    input  logic                         pop_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [ADDR_W-1:0]            head_reg_o,
    output logic [DATA_W-1:0]            head_data_o,
    output logic [DEPTH-1:0]             ent_vld_o,
    output logic [DEPTH-1:0][ADDR_W-1:0] ent_reg_o
);
    // DEPTH is a power of two, so pointers wrap by plain overflow.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] reg_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Pointer and occupancy next-state; simultaneous push and pop both apply.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    // Control state: flushed immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents are meaningless until marked valid by the count.
    always_ff @(posedge clk) begin
        if (push_i) begin
            reg_q[wr_ptr_q]  <= push_reg_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] offs;
            offs         = PTR_W'(i) - rd_ptr_q;
            ent_vld_o[i] = (CNT_W'(offs) < cnt_q);
            ent_reg_o[i] = reg_q[i];
        end
    end

    assign full_o      = (cnt_q == CNT_W'(DEPTH));
    assign empty_o     = (cnt_q == '0);
    assign head_reg_o  = reg_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o));

endmodule

// File: rtl/regwrite_arbiter.sv
// Shares the register file's single write port between ALU and load
// writebacks. Each source queues into its own FIFO; a round-robin arbiter
// drains the heads into a registered write port, and a busy vector marks
// every register with a queued or in-flight write for RAW stall detection.
module regwrite_arbiter #(
    parameter int DATA_W = regwrite_pkg::DATA_W,
    parameter int ADDR_W = regwrite_pkg::ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst,
    regwrite_arbiter_if.slave  wb
);
    import regwrite_pkg::*;

    logic                         alu_push, alu_pop, alu_full, alu_empty;
    logic                         mem_push, mem_pop, mem_full, mem_empty;
    logic [ADDR_W-1:0]            alu_head_reg, mem_head_reg;
    logic [DATA_W-1:0]            alu_head_data, mem_head_data;
    logic [DEPTH-1:0]             alu_ent_vld, mem_ent_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] alu_ent_reg, mem_ent_reg;

    src_e                last_q, last_d;
    logic                regWrite_q, regWrite_d;
    logic [ADDR_W-1:0]   writeReg_q, writeReg_d;
    logic [DATA_W-1:0]   writeData_q, writeData_d;
    logic [NUM_REGS-1:0] busy_vec;

    // Ready depends only on registered occupancy (and reset), never on valid.
    assign wb.aluReady = !alu_full && !rst;
    assign wb.memReady = !mem_full && !rst;

    // Writes to r0 complete the handshake but are dropped here.
    assign alu_push = wb.aluValid && wb.aluReady && (wb.aluReg != '0);
    assign mem_push = wb.memValid && wb.memReady && (wb.memReg != '0);

    wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_alu_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (alu_push),
        .push_reg_i  (wb.aluReg),
        .push_data_i (wb.aluData),
        .pop_i       (alu_pop),
        .full_o      (alu_full),
        .empty_o     (alu_empty),
        .head_reg_o  (alu_head_reg),
        .head_data_o (alu_head_data),
        .ent_vld_o   (alu_ent_vld),
        .ent_reg_o   (alu_ent_reg)
    );

    wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (mem_push),
        .push_reg_i  (wb.memReg),
        .push_data_i (wb.memData),
        .pop_i       (mem_pop),
        .full_o      (mem_full),
        .empty_o     (mem_empty),
        .head_reg_o  (mem_head_reg),
        .head_data_o (mem_head_data),
        .ent_vld_o   (mem_ent_vld),
        .ent_reg_o   (mem_ent_reg)
    );

    // Round-robin grant on the FIFO heads; ALU wins a tie unless it won last.
    always_comb begin
        alu_pop     = 1'b0;
        mem_pop     = 1'b0;
        last_d      = last_q;
        regWrite_d  = 1'b0;
        writeReg_d  = writeReg_q;
        writeData_d = writeData_q;
        if (!alu_empty && (mem_empty || last_q == SRC_MEM)) begin
            alu_pop     = 1'b1;
            last_d      = SRC_ALU;
            regWrite_d  = 1'b1;
            writeReg_d  = alu_head_reg;
            writeData_d = alu_head_data;
        end else if (!mem_empty) begin
            mem_pop     = 1'b1;
            last_d      = SRC_MEM;
            regWrite_d  = 1'b1;
            writeReg_d  = mem_head_reg;
            writeData_d = mem_head_data;
        end
    end

    // Registered write port and last-grant flag; reset primes ALU to win first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q      <= SRC_MEM;
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
        end else begin
            last_q      <= last_d;
            regWrite_q  <= regWrite_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
        end
    end

    // Busy: any live FIFO entry or the write currently on the port.
    always_comb begin
        busy_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_ent_vld[i]) busy_vec[alu_ent_reg[i]] = 1'b1;
            if (mem_ent_vld[i]) busy_vec[mem_ent_reg[i]] = 1'b1;
        end
        if (regWrite_q) busy_vec[writeReg_q] = 1'b1;
        busy_vec[0] = 1'b0;
    end

    assign wb.regWrite  = regWrite_q;
    assign wb.writeReg  = writeReg_q;
    assign wb.writeData = writeData_q;
    assign wb.busy      = busy_vec;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter: a table of per-cycle input/expected
// records followed by hand-built sequences for backpressure, same-register
// back-to-back writes and asynchronous reset in mid-operation.
module tb_regwrite_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    regwrite_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regwrite_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus.slave)
    );

    typedef struct {
        logic        av;
        logic [4:0]  areg;
        logic [31:0] adata;
        logic        mv;
        logic [4:0]  mreg;
        logic [31:0] mdata;
        logic        e_rw;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic [31:0] e_busy;
        logic        e_ar;
        logic        e_mr;
    } vec_t;

    int   n_total = 0;
    int   n_pass  = 0;
    int   step_id = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic av, input int areg, input logic [31:0] adata,
                                input logic mv, input int mreg, input logic [31:0] mdata,
                                input logic rw, input int wr, input logic [31:0] wd,
                                input logic [31:0] bz, input logic ar, input logic mr);
        vec_t v;
        v.av = av;  v.areg = 5'(areg);  v.adata = adata;
        v.mv = mv;  v.mreg = 5'(mreg);  v.mdata = mdata;
        v.e_rw = rw; v.e_wr = 5'(wr); v.e_wd = wd;
        v.e_busy = bz; v.e_ar = ar; v.e_mr = mr;
        return v;
    endfunction

    // Busy mask with a bit set for each nonzero register argument.
    function automatic logic [31:0] bm(input int a, input int b, input int c, input int d);
        logic [31:0] m;
        m = '0;
        if (a != 0) m[a] = 1'b1;
        if (b != 0) m[b] = 1'b1;
        if (c != 0) m[c] = 1'b1;
        if (d != 0) m[d] = 1'b1;
        return m;
    endfunction

    task automatic cmp(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL step%0d %s: got 0x%0h, expected 0x%0h", id, nm, act, exp);
    endtask

    task automatic check_outs(input int id, input vec_t v);
        cmp(id, "regWrite",  32'(bus.regWrite),  32'(v.e_rw));
        cmp(id, "writeReg",  32'(bus.writeReg),  32'(v.e_wr));
        cmp(id, "writeData", bus.writeData,      v.e_wd);
        cmp(id, "busy",      bus.busy,           v.e_busy);
        cmp(id, "aluReady",  32'(bus.aluReady),  32'(v.e_ar));
        cmp(id, "memReady",  32'(bus.memReady),  32'(v.e_mr));
    endtask

    // Drive one cycle of inputs, then check outputs just after the edge.
    task automatic run(input vec_t v);
        bus.aluValid = v.av;  bus.aluReg = v.areg;  bus.aluData = v.adata;
        bus.memValid = v.mv;  bus.memReg = v.mreg;  bus.memData = v.mdata;
        @(posedge clk);
        #1;
        step_id++;
        check_outs(step_id, v);
    endtask

    task automatic idle_inputs();
        bus.aluValid = 1'b0; bus.aluReg = '0; bus.aluData = '0;
        bus.memValid = 1'b0; bus.memReg = '0; bus.memData = '0;
    endtask

    initial begin
        idle_inputs();

        // Reset state while rst is held.
        #2;
        check_outs(0, mk(0,0,0, 0,0,0, 0,0,0, 0, 0,0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Contention: alternating grants starting with ALU reg 1.
        tbl.push_back(mk(0,0,0,          0,0,0,           0,0,0,            0,                1,1));
        tbl.push_back(mk(1,1,32'hA01,    1,11,32'hB0B,    0,0,0,            bm(1,11,0,0),     1,1));
        tbl.push_back(mk(1,2,32'hA02,    1,12,32'hB0C,    1,1,32'hA01,      bm(1,2,11,12),    1,0));
        tbl.push_back(mk(1,3,32'hA03,    1,13,32'hB0D,    1,11,32'hB0B,     bm(2,3,11,12),    0,1));
        tbl.push_back(mk(1,4,32'hA04,    1,13,32'hB0D,    1,2,32'hA02,      bm(2,3,12,13),    1,0));
        tbl.push_back(mk(1,4,32'hA04,    1,14,32'hB0E,    1,12,32'hB0C,     bm(3,4,12,13),    0,1));
        tbl.push_back(mk(0,0,0,          1,14,32'hB0E,    1,3,32'hA03,      bm(3,4,13,14),    1,0));
        tbl.push_back(mk(0,0,0,          0,0,0,           1,13,32'hB0D,     bm(4,13,14,0),    1,1));
        tbl.push_back(mk(0,0,0,          0,0,0,           1,4,32'hA04,      bm(4,14,0,0),     1,1));
        tbl.push_back(mk(0,0,0,          0,0,0,           1,14,32'hB0E,     bm(14,0,0,0),     1,1));
        tbl.push_back(mk(0,0,0,          0,0,0,           0,14,32'hB0E,     0,                1,1));
        // Single write: regWrite two edges after accept, for one cycle.
        tbl.push_back(mk(1,5,32'hDEADBEEF, 0,0,0,         0,14,32'hB0E,     bm(5,0,0,0),      1,1));
        tbl.push_back(mk(0,0,0,          0,0,0,           1,5,32'hDEADBEEF, bm(5,0,0,0),      1,1));
        tbl.push_back(mk(0,0,0,          0,0,0,           0,5,32'hDEADBEEF, 0,                1,1));
        // Register 0: accepted, never written, never busy.
        tbl.push_back(mk(0,0,0,          1,0,32'h1234,    0,5,32'hDEADBEEF, 0,                1,1));
        tbl.push_back(mk(0,0,0,          0,0,0,           0,5,32'hDEADBEEF, 0,                1,1));
        tbl.push_back(mk(0,0,0,          0,0,0,           0,5,32'hDEADBEEF, 0,                1,1));

        for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

        // Backpressure: ALU fills both slots while mem takes alternate grants.
        run(mk(1,20,32'h1014, 1,21,32'h1015, 0,5,32'hDEADBEEF, bm(20,21,0,0),   1,1));
        run(mk(1,22,32'h1016, 1,23,32'h1017, 1,21,32'h1015,    bm(20,21,22,23), 0,1));
        run(mk(1,24,32'h1018, 0,0,0,         1,20,32'h1014,    bm(20,22,23,0),  1,1));
        run(mk(1,24,32'h1018, 0,0,0,         1,23,32'h1017,    bm(22,23,24,0),  0,1));
        run(mk(0,0,0,         0,0,0,         1,22,32'h1016,    bm(22,24,0,0),   1,1));
        run(mk(0,0,0,         0,0,0,         1,24,32'h1018,    bm(24,0,0,0),    1,1));
        run(mk(0,0,0,         0,0,0,         0,24,32'h1018,    0,               1,1));

        // Back-to-back writes to r7: 1 then 2, busy held throughout.
        run(mk(1,7,32'd1,     0,0,0,         0,24,32'h1018,    bm(7,0,0,0),     1,1));
        run(mk(1,7,32'd2,     0,0,0,         1,7,32'd1,        bm(7,0,0,0),     1,1));
        run(mk(0,0,0,         0,0,0,         1,7,32'd2,        bm(7,0,0,0),     1,1));
        run(mk(0,0,0,         0,0,0,         0,7,32'd2,        0,               1,1));

        // Reset mid-operation with both FIFOs holding entries.
        run(mk(1,8,32'h88,    1,9,32'h99,    0,7,32'd2,        bm(8,9,0,0),     1,1));
        run(mk(1,10,32'h8A,   1,12,32'h9C,   1,9,32'h99,       bm(8,9,10,12),   0,1));
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        check_outs(100, mk(0,0,0, 0,0,0, 0,0,0, 0, 0,0));
        @(posedge clk);
        #1;
        check_outs(101, mk(0,0,0, 0,0,0, 0,0,0, 0, 0,0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outs(102, mk(0,0,0, 0,0,0, 0,0,0, 0, 1,1));
        run(mk(0,0,0,         0,0,0,         0,0,0,            0,               1,1));
        run(mk(0,0,0,         0,0,0,         0,0,0,            0,               1,1));
        // After reset ALU wins the first contended grant again.
        run(mk(1,3,32'h33,    1,4,32'h44,    0,0,0,            bm(3,4,0,0),     1,1));
        run(mk(0,0,0,         0,0,0,         1,3,32'h33,       bm(3,4,0,0),     1,1));
        run(mk(0,0,0,         0,0,0,         1,4,32'h44,       bm(4,0,0,0),     1,1));
        run(mk(0,0,0,         0,0,0,         0,4,32'h44,       0,               1,1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regwrite_arbiter.md
Name: regwrite_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: ALU results and memory-load results.
- Each source gets its own small FIFO; a round-robin arbiter drains the FIFOs into registered regWrite/writeReg/writeData outputs that drive the register file directly.
- A per-register busy vector flags registers with queued or in-flight writes, so the decode stage can stall on RAW hazards.

Parameters:
- DATA_W, 32, data width of each write.
- ADDR_W, 5, register index width (32 registers).
- DEPTH, 2, entries per source FIFO; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- aluValid  in  1  ALU writeback request valid.
- aluReady  out  1  ALU FIFO can accept.
- aluReg  in  ADDR_W  ALU destination register.
- aluData  in  DATA_W  ALU result.
- memValid  in  1  load writeback request valid.
- memReady  out  1  load FIFO can accept.
- memReg  in  ADDR_W  load destination register.
- memData  in  DATA_W  load data.
- regWrite  out  1  register file write enable (registered).
- writeReg  out  ADDR_W  register file write index (registered).
- writeData  out  DATA_W  register file write data (registered).
- busy  out  32  bit r set means register r has a pending or in-flight write.

Behaviour:
- Reset (asynchronous assert, takes effect immediately):
  - both FIFOs flushed;
  - regWrite=0, writeReg=0, writeData=0, busy=0;
  - aluReady=0, memReady=0 while rst is high;
  - arbiter pointer set so ALU wins the first contended grant.
- Reset mid-operation: all queued writes are discarded; none reach the register file.
- Handshake:
  - A transfer occurs on any rising edge with xValid && xReady.
  - xReady = !full, derived from registered occupancy only; no combinational path from either valid to either ready.
  - A full FIFO deasserts ready even if it pops in the same cycle.
  - Enqueue and dequeue of the same FIFO in one cycle are both honoured.
- Register 0:
  - A request with xReg==0 completes the handshake normally but is discarded: not stored, never issued.
  - busy[0] is always 0.
- Arbitration, evaluated each cycle on the FIFO heads:
  - Neither FIFO non-empty: regWrite goes 0 at the next edge; writeReg and writeData hold their previous values.
  - Exactly one non-empty: that head is granted.
  - Both non-empty: the source not granted most recently wins.
  - The last-grant flag updates only on an actual grant.
- On a grant, at the next edge:
  - the granted head is popped;
  - regWrite=1 and writeReg/writeData are loaded from the head.
- Latency:
  - Handshake at edge N, with the FIFO empty and uncontended: regWrite high during cycle N+1→N+2; the register file captures at edge N+2.
  - Throughput is 1 write per cycle in aggregate.
- Ordering:
  - Per-source order is preserved.
  - No ordering between sources; producers must not issue same-register writes from both sources concurrently.
  - Same-source, same-register writes retire in order.
- busy[r] = OR of:
  - any valid entry in either FIFO with reg==r;
  - (regWrite && writeReg==r).
  - busy is combinational from registered state only.
  - It clears in the cycle after the last pending write to r is presented.
- Occupancy counters range 0..DEPTH.
  - Read and write pointers wrap modulo DEPTH.
  - Overflow and underflow cannot occur by construction; an assertion flags either.

Decomposition:
- Package regwrite_pkg: DATA_W, ADDR_W, NUM_REGS=32, source-index constants SRC_ALU=0 and SRC_MEM=1.
- Sub-module wb_fifo, instantiated twice:
  - DEPTH entries of {reg, data};
  - push/pop/full/empty interface;
  - exposes per-entry valid, reg vector for busy generation.
- Arbiter and output register live in the top level.

Test Plan:
- Single write: after reset, aluValid=1, aluReg=5, aluData=0xDEADBEEF for one accepted cycle → regWrite=1 with writeReg=5, writeData=0xDEADBEEF exactly 2 edges later for 1 cycle; busy[5]=1 from the cycle after accept until regWrite falls.
- Contention: both sources hold valid every cycle (ALU reg 1..4, mem reg 11..14) → outputs alternate ALU, mem, ALU, mem starting with ALU reg 1; no entry lost or duplicated; per-source order kept.
- Backpressure: with DEPTH=2, ALU pushes 2 entries while mem keeps the arbiter busy → aluReady=0 after the 2nd accept and returns to 1 the cycle after the first ALU pop; the 3rd request is held and accepted later.
- Register 0: memValid with memReg=0, memData=0x1234 → handshake completes, regWrite never asserts, busy stays 0.
- Reset mid-operation: fill both FIFOs, assert rst asynchronously between edges → regWrite, writeReg, writeData and busy read 0 immediately; after release no stale write is issued and both readies are 1.
- Back-to-back same register: ALU writes reg 7 =1 then =2 on consecutive cycles → register file sees 1 then 2; busy[7] stays high continuously until the second write is presented.
